vc_arbiter: RTL and testbench

- Output-side scheduler for the transmit layer.
- Drains the two virtual-channel FIFOs (VC0, VC1) fed by the initial-logic demux.
- Routes each word to destination FIFO D0 or D1, selected by a header bit.
- Arbitration: VC0 has strict priority with an anti-starvation burst limit for VC1. A word is never popped unless its destination FIFO is unpaused.

---
 rtl/vc_arbiter.sv | 153 +++++++++++++++
 tb/tb_vc_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter.sv
// Output-side scheduler: drains the two virtual-channel FIFOs into destination FIFOs D0/D1.
// VC0 has strict priority, bounded by a burst limit whenever VC1 is also eligible.
module vc_arbiter #(
    parameter int data_width = 6,
    parameter int VC0_BURST  = 4,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] data_vc0,
    input  logic [data_width-1:0] data_vc1,
    input  logic                  empty_vc0,
    input  logic                  empty_vc1,
    input  logic                  pause_d0,
    input  logic                  pause_d1,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic [data_width-1:0] data_out,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  cnt_d0,
    output logic [CNT_WIDTH-1:0]  cnt_d1
);

    localparam int          DEST_BIT  = data_width - 2;
    localparam logic [3:0]  BURST_LIM = 4'(VC0_BURST);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_burst_cnt;
    logic [3:0]            w_burst_nxt;
    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_allow;
    logic                  w_grant0;
    logic                  w_grant1;
    logic [data_width-1:0] w_word;

    // Eligibility uses the destination of each head word against its pause input.
    always_comb begin
        w_elig0 = 1'b0;
        w_elig1 = 1'b0;
        if (!empty_vc0) begin
            w_elig0 = data_vc0[DEST_BIT] ? !pause_d1 : !pause_d0;
        end else begin
            w_elig0 = 1'b0;
        end
        if (!empty_vc1) begin
            w_elig1 = data_vc1[DEST_BIT] ? !pause_d1 : !pause_d0;
        end else begin
            w_elig1 = 1'b0;
        end
    end

    // Grant selection and burst counter update; nothing is granted in INIT or while reset is high.
    always_comb begin
        w_allow     = !reset && ((r_state == ST_IDLE) || (r_state == ST_ACTIVE));
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_burst_nxt = r_burst_cnt;
        if (w_allow) begin
            if (w_elig0 && w_elig1) begin
                if (r_burst_cnt < BURST_LIM) begin
                    w_grant0    = 1'b1;
                    w_burst_nxt = r_burst_cnt + 4'd1;
                end else begin
                    w_grant1    = 1'b1;
                    w_burst_nxt = 4'd0;
                end
            end else if (w_elig0) begin
                w_grant0    = 1'b1;
                w_burst_nxt = 4'd0;
            end else if (w_elig1) begin
                w_grant1    = 1'b1;
                w_burst_nxt = 4'd0;
            end else begin
                w_burst_nxt = r_burst_cnt;
            end
        end else begin
            w_burst_nxt = r_burst_cnt;
        end
        w_word = w_grant0 ? data_vc0 : data_vc1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_burst_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:   w_state_nxt = ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: w_state_nxt = (w_elig0 || w_elig1) ? ST_ACTIVE : ST_IDLE;
            default:   w_state_nxt = ST_INIT;
        endcase
    end

    // FSM outputs: pops follow the grant, idle decodes the state.
    always_comb begin
        pop_vc0 = w_grant0;
        pop_vc1 = w_grant1;
        case (r_state)
            ST_IDLE: idle = 1'b1;
            default: idle = 1'b0;
        endcase
    end

    // Word captured in the pop cycle is pushed to its destination the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= {data_width{1'b0}};
            push_d0  <= 1'b0;
            push_d1  <= 1'b0;
        end else begin
            push_d0 <= (w_grant0 || w_grant1) && !w_word[DEST_BIT];
            push_d1 <= (w_grant0 || w_grant1) && w_word[DEST_BIT];
            if (w_grant0 || w_grant1) begin
                data_out <= w_word;
            end else begin
                data_out <= data_out;
            end
        end
    end

    // Per-destination push counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_d0 <= {CNT_WIDTH{1'b0}};
            cnt_d1 <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_d0 <= push_d0 ? cnt_d0 + CNT_ONE : cnt_d0;
            cnt_d1 <= push_d1 ? cnt_d1 + CNT_ONE : cnt_d1;
        end
    end

endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: directed vector table, corner sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_vc_arbiter;

    localparam int DW    = 6;
    localparam int BURST = 4;
    localparam int CW    = 5;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_vc0, data_vc1;
    logic          empty_vc0, empty_vc1, pause_d0, pause_d1;
    logic          pop_vc0, pop_vc1, push_d0, push_d1, idle;
    logic [DW-1:0] data_out;
    logic [CW-1:0] cnt_d0, cnt_d1;

    vc_arbiter #(.data_width(DW), .VC0_BURST(BURST), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .data_vc0(data_vc0), .data_vc1(data_vc1),
        .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
        .pause_d0(pause_d0), .pause_d1(pause_d1),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .data_out(data_out), .push_d0(push_d0), .push_d1(push_d1),
        .idle(idle), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_since;     // edges since last reset edge, saturating at 2
    bit          m_any_prev;  // any VC eligible in the previous cycle
    int          m_streak;    // consecutive contended VC0 wins
    logic [DW-1:0] m_dout;
    bit          m_push0, m_push1;
    int          m_cnt0, m_cnt1;

    // Last observed outputs
    logic obs_pop0, obs_pop1, obs_push0, obs_push1, obs_idle;
    logic [DW-1:0] obs_dout;
    logic [CW-1:0] obs_cnt0;

    typedef struct {
        logic          rst;
        logic [DW-1:0] d0, d1;
        logic          e0, e1, p0, p1;
        logic          x_pop0, x_pop1, x_push0, x_push1;
        logic [DW-1:0] x_dout;
        logic          x_idle;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_since    = 0;
        m_any_prev = 1'b0;
        m_streak   = 0;
        m_dout     = '0;
        m_push0    = 1'b0;
        m_push1    = 1'b0;
        m_cnt0     = 0;
        m_cnt1     = 0;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model, cross the rising edge.
    task automatic step(input logic rst, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic e0, input logic e1, input logic p0, input logic p1);
        bit el0, el1, allow, g0, g1, x_idle;
        logic [DW-1:0] w;
        reset = rst; data_vc0 = d0; data_vc1 = d1;
        empty_vc0 = e0; empty_vc1 = e1; pause_d0 = p0; pause_d1 = p1;
        @(negedge clk);
        el0   = !e0 && !(d0[DW-2] ? p1 : p0);
        el1   = !e1 && !(d1[DW-2] ? p1 : p0);
        allow = !rst && (m_since >= 1);
        g0 = 1'b0; g1 = 1'b0;
        if (allow) begin
            if (el0 && el1) begin
                if (m_streak < BURST) g0 = 1'b1; else g1 = 1'b1;
            end else if (el0) g0 = 1'b1;
            else if (el1) g1 = 1'b1;
        end
        x_idle = (m_since == 1) || (m_since >= 2 && !m_any_prev);

        obs_pop0 = pop_vc0; obs_pop1 = pop_vc1; obs_push0 = push_d0; obs_push1 = push_d1;
        obs_idle = idle; obs_dout = data_out; obs_cnt0 = cnt_d0;
        chk("pop_vc0",  32'(pop_vc0),  32'(g0));
        chk("pop_vc1",  32'(pop_vc1),  32'(g1));
        chk("push_d0",  32'(push_d0),  32'(m_push0));
        chk("push_d1",  32'(push_d1),  32'(m_push1));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("idle",     32'(idle),     32'(x_idle));
        chk("cnt_d0",   32'(cnt_d0),   32'(m_cnt0));
        chk("cnt_d1",   32'(cnt_d1),   32'(m_cnt1));

        if (rst) begin
            model_reset();
        end else begin
            m_cnt0 = (m_cnt0 + (m_push0 ? 1 : 0)) % (1 << CW);
            m_cnt1 = (m_cnt1 + (m_push1 ? 1 : 0)) % (1 << CW);
            w = g0 ? d0 : d1;
            m_push0 = (g0 || g1) && !w[DW-2];
            m_push1 = (g0 || g1) && w[DW-2];
            if (g0 || g1) m_dout = w;
            if (allow) begin
                if (el0 && el1) m_streak = g0 ? m_streak + 1 : 0;
                else if (el0 || el1) m_streak = 0;
            end
            m_any_prev = el0 || el1;
            if (m_since < 2) m_since++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst   d0         d1         e0 e1 p0 p1  pop0 pop1 psh0 psh1 dout       idle
        tbl[0]  = '{1'b1, 6'b000001, 6'b000010, 0, 0, 0, 0,   0,   0,   0,   0,  6'b000000, 0};
        tbl[1]  = '{1'b0, 6'b000001, 6'b000010, 0, 0, 0, 0,   0,   0,   0,   0,  6'b000000, 0};
        tbl[2]  = '{1'b0, 6'b000001, 6'b000010, 0, 0, 0, 0,   1,   0,   0,   0,  6'b000000, 1};
        tbl[3]  = '{1'b0, 6'b010011, 6'b000000, 0, 1, 0, 0,   1,   0,   1,   0,  6'b000001, 0};
        tbl[4]  = '{1'b0, 6'b000000, 6'b000000, 1, 1, 0, 0,   0,   0,   0,   1,  6'b010011, 0};
        tbl[5]  = '{1'b0, 6'b000000, 6'b000000, 1, 1, 0, 0,   0,   0,   0,   0,  6'b010011, 1};
        tbl[6]  = '{1'b0, 6'b000101, 6'b110000, 0, 0, 0, 1,   1,   0,   0,   0,  6'b010011, 1};
        tbl[7]  = '{1'b0, 6'b000111, 6'b110000, 0, 0, 1, 0,   0,   1,   1,   0,  6'b000101, 0};
        tbl[8]  = '{1'b0, 6'b000000, 6'b000000, 1, 1, 0, 0,   0,   0,   0,   1,  6'b110000, 0};
        tbl[9]  = '{1'b1, 6'b000001, 6'b000000, 0, 1, 0, 0,   0,   0,   0,   0,  6'b110000, 1};
        tbl[10] = '{1'b0, 6'b000001, 6'b000000, 0, 1, 0, 0,   0,   0,   0,   0,  6'b000000, 0};

        reset = 1'b1; data_vc0 = '0; data_vc1 = '0;
        empty_vc0 = 1'b1; empty_vc1 = 1'b1; pause_d0 = 1'b0; pause_d1 = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].d0, tbl[i].d1, tbl[i].e0, tbl[i].e1, tbl[i].p0, tbl[i].p1);
            chk($sformatf("tbl%0d_pop0", i),  32'(obs_pop0),  32'(tbl[i].x_pop0));
            chk($sformatf("tbl%0d_pop1", i),  32'(obs_pop1),  32'(tbl[i].x_pop1));
            chk($sformatf("tbl%0d_push0", i), 32'(obs_push0), 32'(tbl[i].x_push0));
            chk($sformatf("tbl%0d_push1", i), 32'(obs_push1), 32'(tbl[i].x_push1));
            chk($sformatf("tbl%0d_dout", i),  32'(obs_dout),  32'(tbl[i].x_dout));
            chk($sformatf("tbl%0d_idle", i),  32'(obs_idle),  32'(tbl[i].x_idle));
        end

        // Burst limit: both VCs eligible toward D0
        step(1'b1, 6'b000000, 6'b000000, 1, 1, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            step(1'b0, {2'b00, 4'(k)}, 6'b001111, 0, 0, 0, 0);
            if (k >= 2) begin
                chk("burst_pop0", 32'(obs_pop0), ((k - 2) % 5 == 4) ? 32'd0 : 32'd1);
                chk("burst_pop1", 32'(obs_pop1), ((k - 2) % 5 == 4) ? 32'd1 : 32'd0);
            end
            if (k >= 3) chk("burst_push0", 32'(obs_push0), 32'd1);
        end
        step(1'b0, 6'b000000, 6'b000000, 1, 1, 0, 0);
        step(1'b0, 6'b000000, 6'b000000, 1, 1, 0, 0);
        chk("burst_cnt_d0", 32'(obs_cnt0), 32'd10);

        // Counter wrap: 33 pushes to D0
        step(1'b1, 6'b000000, 6'b000000, 1, 1, 0, 0);
        for (int k = 1; k <= 36; k++) begin
            if (k <= 34) step(1'b0, 6'b001010, 6'b000000, 0, 1, 0, 0);
            else         step(1'b0, 6'b000000, 6'b000000, 1, 1, 0, 0);
            if (k == 34) chk("wrap_cnt31", 32'(obs_cnt0), 32'd31);
            if (k == 35) chk("wrap_cnt0",  32'(obs_cnt0), 32'd0);
            if (k == 36) chk("wrap_cnt1",  32'(obs_cnt0), 32'd1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) == 0),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
